id_ex_stage_reg: RTL and testbench
==================================

// Module: id_ex_stage_reg
// PURPOSE
//  ID/EX pipeline register directly downstream of the register file. Captures read
//  operands, rs/rt/rd, extended immediate, PC+4 and the control bundle on posedge clk.
//  Detects load-use hazards, inserts bubbles, honours external stall/flush, and keeps
//  a saturating bubble counter. The register file writes on negedge, so posedge
//  capture already sees that cycle's WB data; no WB bypass is needed here.
// PARAMETERS
//  CTRL_W   12  width of decoded control bundle (bit layout in pipeline_pkg)
//  CNT_W    16  width of bubble/stall statistics counter
// PORTS
//  clk            in   1       pipeline clock, capture on rising edge
//  rst            in   1       reset, asynchronous, active-low
//  id_valid       in   1       ID holds a real instruction
//  id_rs          in   5       source register 1 address (also regfile readRegister1)
//  id_rt          in   5       source register 2 address (also regfile readRegister2)
//  id_rd          in   5       destination address for R-type
//  id_uses_rs     in   1       instruction reads rs
//  id_uses_rt     in   1       instruction reads rt
//  id_rdata1      in   32      regfile readData1
//  id_rdata2      in   32      regfile readData2
//  id_imm16       in   16      raw immediate
//  id_zero_ext    in   1       1: zero-extend imm16, 0: sign-extend
//  id_pc4         in   32      PC+4 of the ID instruction
//  id_ctrl        in   CTRL_W  decoded control bundle
//  flush          in   1       branch/jump redirect: squash ID instruction
//  ext_stall      in   1       downstream (memory) stall: freeze whole register
//  ex_valid       out  1       EX holds a real instruction
//  ex_rs/ex_rt/ex_rd out 5     registered addresses
//  ex_rdata1/ex_rdata2 out 32  registered operands
//  ex_imm32       out  32      registered extended immediate
//  ex_pc4         out  32      registered PC+4
//  ex_ctrl        out  CTRL_W  registered control (all-zero when bubble)
//  hazard_stall   out  1       combinational: hold PC and IF/ID this cycle
//  bubble_count   out  CNT_W   saturating count of bubbles inserted
// BEHAVIOUR
//  - Reset (rst=0, async): every ex_* output 0, ex_valid=0, bubble_count=0.
//  - Latency: 1 cycle ID -> EX. hazard_stall is combinational, same cycle.
//  - load_use = ex_valid & ex_ctrl[MEM_READ] & (ex_rt!=0) &
//      ((id_uses_rs & id_rs==ex_rt) | (id_uses_rt & id_rt==ex_rt)) & id_valid.
//  - hazard_stall = load_use | ext_stall.
//  - Per posedge, priority flush > ext_stall > load_use > normal:
//    flush:     load bubble (ex_valid=0, ex_ctrl=0, datapath fields 0), count++.
//    ext_stall: hold all ex_* unchanged; no count.
//    load_use:  load bubble, count++; IF/ID holds so instruction re-presents next cycle.
//    normal:    load all id_* fields; ex_valid=id_valid; ex_ctrl=id_valid?id_ctrl:0.
//  - imm32 = id_zero_ext ? {16'b0,imm16} : {{16{imm16[15]}},imm16}.
//  - Register $0 as ex_rt never triggers a hazard.
//  - bubble_count saturates at all-ones; never wraps.
//  - Reset mid-stall: state clears immediately; first post-reset edge is a normal load.
// STRUCTURE
//  - pipeline_pkg: CTRL_W, control bit indices (MEM_READ, MEM_WRITE, REG_WRITE,
//    ALU_SRC, REG_DST, ALU_OP field), BUBBLE_CTRL constant (all zero).
//  - Sub-module load_use_detect (combinational hazard compare); rest inline.
// TESTING
//  1 Reset: rst=0 mid-run -> all ex_* 0, ex_valid=0, bubble_count=0 without clock edge.
//  2 Pass-through: rs=3,rt=4,rdata1=0x11,rdata2=0x22,imm16=0x8001,sext -> next cycle
//    ex_rdata1=0x11, ex_rdata2=0x22, ex_imm32=0xFFFF8001, ex_valid=1; zext -> 0x00008001.
//  3 Load-use: EX=lw with ex_rt=5, ID add uses rs=5 -> hazard_stall=1, next ex_valid=0,
//    ex_ctrl=0, bubble_count=1; following cycle add loads normally.
//  4 $0 and non-use: ex lw rt=0 with id_rs=0, or id_uses_rt=0 with rt match -> no stall.
//  5 Simultaneous: flush=1 with ext_stall=1 and load_use=1 -> bubble loaded, count++.
//  6 ext_stall=1 for 3 cycles -> ex_* frozen, count unchanged; force count=0xFFFF,
//    trigger bubble -> stays 0xFFFF.

Source files
------------

// File: rtl/id_ex_stage_reg_pkg.sv
// Shared pipeline definitions: control-bundle layout and the bubble constant.
// The decode stage and the ID/EX register both take their bit positions from here.
package pipeline_pkg;

  localparam int CTRL_W = 12;

  // Control bundle bit positions
  localparam int MEM_READ   = 0;
  localparam int MEM_WRITE  = 1;
  localparam int REG_WRITE  = 2;
  localparam int ALU_SRC    = 3;
  localparam int REG_DST    = 4;
  localparam int ALU_OP_LSB = 5;
  localparam int ALU_OP_W   = 4;
  localparam int ALU_OP_MSB = ALU_OP_LSB + ALU_OP_W - 1;
  localparam int MEM_TO_REG = 9;
  localparam int BRANCH     = 10;
  localparam int JUMP       = 11;

  localparam logic [CTRL_W-1:0] BUBBLE_CTRL = '0;

  typedef enum logic [1:0] {
    ACT_LOAD   = 2'd0,
    ACT_HOLD   = 2'd1,
    ACT_BUBBLE = 2'd2
  } ex_action_e;

  function automatic logic [31:0] extend_imm(input logic [15:0] imm16,
                                             input logic        zero_ext);
    return zero_ext ? {16'b0, imm16} : {{16{imm16[15]}}, imm16};
  endfunction

endpackage

// File: rtl/id_ex_stage_reg_load_use_detect.sv
// Load-use hazard compare: the instruction in EX is a load whose destination
// is a source operand of the instruction currently in ID.
module load_use_detect (
  input  logic       ex_valid,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rt,
  input  logic       id_valid,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rs,
  input  logic       id_uses_rt,
  output logic       load_use
);

  logic rs_match;
  logic rt_match;

  always_comb begin
    rs_match = id_uses_rs && (id_rs == ex_rt);
    rt_match = id_uses_rt && (id_rt == ex_rt);
    // $0 is hard-wired, so a load targeting it can never produce a dependency
    load_use = ex_valid && ex_mem_read && (ex_rt != 5'd0) &&
               (rs_match || rt_match) && id_valid;
  end

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use bubble insertion, external stall/flush
// and a saturating bubble counter. Regfile writes on negedge, so no WB bypass here.
module id_ex_stage_reg
  import pipeline_pkg::*;
#(
  parameter int CTRL_W = pipeline_pkg::CTRL_W,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic [4:0]        id_rd,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic [31:0]       id_rdata1,
  input  logic [31:0]       id_rdata2,
  input  logic [15:0]       id_imm16,
  input  logic              id_zero_ext,
  input  logic [31:0]       id_pc4,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              flush,
  input  logic              ext_stall,
  output logic              ex_valid,
  output logic [4:0]        ex_rs,
  output logic [4:0]        ex_rt,
  output logic [4:0]        ex_rd,
  output logic [31:0]       ex_rdata1,
  output logic [31:0]       ex_rdata2,
  output logic [31:0]       ex_imm32,
  output logic [31:0]       ex_pc4,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic              hazard_stall,
  output logic [CNT_W-1:0]  bubble_count
);

  logic              ex_valid_q,  ex_valid_d;
  logic [4:0]        ex_rs_q,     ex_rs_d;
  logic [4:0]        ex_rt_q,     ex_rt_d;
  logic [4:0]        ex_rd_q,     ex_rd_d;
  logic [31:0]       ex_rdata1_q, ex_rdata1_d;
  logic [31:0]       ex_rdata2_q, ex_rdata2_d;
  logic [31:0]       ex_imm32_q,  ex_imm32_d;
  logic [31:0]       ex_pc4_q,    ex_pc4_d;
  logic [CTRL_W-1:0] ex_ctrl_q,   ex_ctrl_d;
  logic [CNT_W-1:0]  bubble_count_q, bubble_count_d;

  logic       load_use;
  ex_action_e action;

  load_use_detect u_load_use_detect (
    .ex_valid    (ex_valid_q),
    .ex_mem_read (ex_ctrl_q[MEM_READ]),
    .ex_rt       (ex_rt_q),
    .id_valid    (id_valid),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_uses_rs  (id_uses_rs),
    .id_uses_rt  (id_uses_rt),
    .load_use    (load_use)
  );

  // Priority: flush > ext_stall > load_use > normal load
  always_comb begin
    action = ACT_LOAD;
    if (flush) begin
      action = ACT_BUBBLE;
    end else if (ext_stall) begin
      action = ACT_HOLD;
    end else if (load_use) begin
      action = ACT_BUBBLE;
    end
  end

  always_comb begin
    ex_valid_d     = ex_valid_q;
    ex_rs_d        = ex_rs_q;
    ex_rt_d        = ex_rt_q;
    ex_rd_d        = ex_rd_q;
    ex_rdata1_d    = ex_rdata1_q;
    ex_rdata2_d    = ex_rdata2_q;
    ex_imm32_d     = ex_imm32_q;
    ex_pc4_d       = ex_pc4_q;
    ex_ctrl_d      = ex_ctrl_q;
    bubble_count_d = bubble_count_q;
    case (action)
      ACT_LOAD: begin
        ex_valid_d  = id_valid;
        ex_rs_d     = id_rs;
        ex_rt_d     = id_rt;
        ex_rd_d     = id_rd;
        ex_rdata1_d = id_rdata1;
        ex_rdata2_d = id_rdata2;
        ex_imm32_d  = extend_imm(id_imm16, id_zero_ext);
        ex_pc4_d    = id_pc4;
        ex_ctrl_d   = id_valid ? id_ctrl : BUBBLE_CTRL;
      end
      ACT_BUBBLE: begin
        ex_valid_d  = 1'b0;
        ex_rs_d     = '0;
        ex_rt_d     = '0;
        ex_rd_d     = '0;
        ex_rdata1_d = '0;
        ex_rdata2_d = '0;
        ex_imm32_d  = '0;
        ex_pc4_d    = '0;
        ex_ctrl_d   = BUBBLE_CTRL;
        if (bubble_count_q != {CNT_W{1'b1}}) begin
          bubble_count_d = bubble_count_q + CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_valid_q     <= 1'b0;
      ex_rs_q        <= '0;
      ex_rt_q        <= '0;
      ex_rd_q        <= '0;
      ex_rdata1_q    <= '0;
      ex_rdata2_q    <= '0;
      ex_imm32_q     <= '0;
      ex_pc4_q       <= '0;
      ex_ctrl_q      <= '0;
      bubble_count_q <= '0;
    end else begin
      ex_valid_q     <= ex_valid_d;
      ex_rs_q        <= ex_rs_d;
      ex_rt_q        <= ex_rt_d;
      ex_rd_q        <= ex_rd_d;
      ex_rdata1_q    <= ex_rdata1_d;
      ex_rdata2_q    <= ex_rdata2_d;
      ex_imm32_q     <= ex_imm32_d;
      ex_pc4_q       <= ex_pc4_d;
      ex_ctrl_q      <= ex_ctrl_d;
      bubble_count_q <= bubble_count_d;
    end
  end

  always_comb begin
    ex_valid     = ex_valid_q;
    ex_rs        = ex_rs_q;
    ex_rt        = ex_rt_q;
    ex_rd        = ex_rd_q;
    ex_rdata1    = ex_rdata1_q;
    ex_rdata2    = ex_rdata2_q;
    ex_imm32     = ex_imm32_q;
    ex_pc4       = ex_pc4_q;
    ex_ctrl      = ex_ctrl_q;
    bubble_count = bubble_count_q;
    hazard_stall = load_use || ext_stall;
  end

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Directed bench for id_ex_stage_reg; a second narrow-counter instance shows saturation.
module tb_id_ex_stage_reg;

  localparam int CTRL_W = 12;

  // Control encodings built from the documented bit layout
  localparam logic [11:0] C_LW  = 12'h20D; // MEM_READ|REG_WRITE|ALU_SRC|MEM_TO_REG
  localparam logic [11:0] C_ADD = 12'h054; // REG_WRITE|REG_DST|ALU_OP=2
  localparam logic [11:0] C_MIX = 12'h0F4;

  logic              clk = 1'b0;
  logic              rst;
  logic              id_valid, id_uses_rs, id_uses_rt, id_zero_ext;
  logic [4:0]        id_rs, id_rt, id_rd;
  logic [31:0]       id_rdata1, id_rdata2, id_pc4;
  logic [15:0]       id_imm16;
  logic [CTRL_W-1:0] id_ctrl;
  logic              flush, ext_stall;

  logic              ex_valid, hazard_stall;
  logic [4:0]        ex_rs, ex_rt, ex_rd;
  logic [31:0]       ex_rdata1, ex_rdata2, ex_imm32, ex_pc4;
  logic [CTRL_W-1:0] ex_ctrl;
  logic [15:0]       bubble_count;

  logic              s_valid, s_hazard;
  logic [4:0]        s_rs, s_rt, s_rd;
  logic [31:0]       s_rdata1, s_rdata2, s_imm32, s_pc4;
  logic [CTRL_W-1:0] s_ctrl;
  logic [1:0]        s_count;

  int checks   = 0;
  int failures = 0;
  int exp_cnt  = 0;

  id_ex_stage_reg #(.CTRL_W(CTRL_W), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rd(id_rd), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_rdata1(id_rdata1), .id_rdata2(id_rdata2), .id_imm16(id_imm16),
    .id_zero_ext(id_zero_ext), .id_pc4(id_pc4), .id_ctrl(id_ctrl),
    .flush(flush), .ext_stall(ext_stall), .ex_valid(ex_valid), .ex_rs(ex_rs),
    .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_rdata1(ex_rdata1), .ex_rdata2(ex_rdata2),
    .ex_imm32(ex_imm32), .ex_pc4(ex_pc4), .ex_ctrl(ex_ctrl),
    .hazard_stall(hazard_stall), .bubble_count(bubble_count)
  );

  id_ex_stage_reg #(.CTRL_W(CTRL_W), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rd(id_rd), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_rdata1(id_rdata1), .id_rdata2(id_rdata2), .id_imm16(id_imm16),
    .id_zero_ext(id_zero_ext), .id_pc4(id_pc4), .id_ctrl(id_ctrl),
    .flush(flush), .ext_stall(ext_stall), .ex_valid(s_valid), .ex_rs(s_rs),
    .ex_rt(s_rt), .ex_rd(s_rd), .ex_rdata1(s_rdata1), .ex_rdata2(s_rdata2),
    .ex_imm32(s_imm32), .ex_pc4(s_pc4), .ex_ctrl(s_ctrl),
    .hazard_stall(s_hazard), .bubble_count(s_count)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Driver
  task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic urs, input logic urt,
                        input logic [31:0] d1, input logic [31:0] d2,
                        input logic [15:0] imm, input logic zext,
                        input logic [31:0] pc4, input logic [11:0] ctrl);
    id_valid = v;  id_rs = rs;  id_rt = rt;  id_rd = rd;
    id_uses_rs = urs;  id_uses_rt = urt;
    id_rdata1 = d1;  id_rdata2 = d2;  id_imm16 = imm;  id_zero_ext = zext;
    id_pc4 = pc4;  id_ctrl = ctrl;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_valid"}, {31'b0, ex_valid}, 32'd0);
    check({tag, "_rs"}, {27'b0, ex_rs}, 32'd0);
    check({tag, "_rt"}, {27'b0, ex_rt}, 32'd0);
    check({tag, "_rd"}, {27'b0, ex_rd}, 32'd0);
    check({tag, "_rdata1"}, ex_rdata1, 32'd0);
    check({tag, "_rdata2"}, ex_rdata2, 32'd0);
    check({tag, "_imm32"}, ex_imm32, 32'd0);
    check({tag, "_pc4"}, ex_pc4, 32'd0);
    check({tag, "_ctrl"}, {20'b0, ex_ctrl}, 32'd0);
  endtask

  task automatic check_count(input string tag);
    check({tag, "_cnt"}, {16'b0, bubble_count}, exp_cnt);
    check({tag, "_satcnt"}, {30'b0, s_count}, (exp_cnt > 3) ? 32'd3 : exp_cnt);
  endtask

  initial begin
    rst = 1'b0;
    flush = 1'b0;
    ext_stall = 1'b0;
    set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 32'd0, 32'd0, 16'd0, 1'b0, 32'd0, 12'd0);
    #1;
    check_zero("reset_init");
    check_count("reset_init");
    tick();
    tick();
    rst = 1'b1;

    // Pass-through, sign then zero extension
    set_id(1'b1, 5'd3, 5'd4, 5'd7, 1'b1, 1'b1, 32'h11, 32'h22, 16'h8001, 1'b0,
           32'h100, C_MIX);
    tick();
    check("pt_valid", {31'b0, ex_valid}, 32'd1);
    check("pt_rs", {27'b0, ex_rs}, 32'd3);
    check("pt_rt", {27'b0, ex_rt}, 32'd4);
    check("pt_rd", {27'b0, ex_rd}, 32'd7);
    check("pt_rdata1", ex_rdata1, 32'h11);
    check("pt_rdata2", ex_rdata2, 32'h22);
    check("pt_sext", ex_imm32, 32'hFFFF8001);
    check("pt_pc4", ex_pc4, 32'h100);
    check("pt_ctrl", {20'b0, ex_ctrl}, {20'b0, C_MIX});
    id_zero_ext = 1'b1;
    tick();
    check("pt_zext", ex_imm32, 32'h00008001);
    id_valid = 1'b0;
    tick();
    check("pt_invalid_valid", {31'b0, ex_valid}, 32'd0);
    check("pt_invalid_ctrl", {20'b0, ex_ctrl}, 32'd0);

    // Load-use: lw rt=5 then add using rs=5
    set_id(1'b1, 5'd1, 5'd5, 5'd0, 1'b1, 1'b0, 32'h40, 32'h0, 16'h0004, 1'b0,
           32'h200, C_LW);
    tick();
    set_id(1'b1, 5'd5, 5'd6, 5'd8, 1'b1, 1'b1, 32'hA5, 32'h5A, 16'h0, 1'b0,
           32'h204, C_ADD);
    #1;
    check("lu_hazard", {31'b0, hazard_stall}, 32'd1);
    tick();
    exp_cnt++;
    check_zero("lu_bubble");
    check_count("lu_bubble");
    check("lu_hazard_gone", {31'b0, hazard_stall}, 32'd0);
    tick();
    check("lu_reload_valid", {31'b0, ex_valid}, 32'd1);
    check("lu_reload_ctrl", {20'b0, ex_ctrl}, {20'b0, C_ADD});
    check("lu_reload_rs", {27'b0, ex_rs}, 32'd5);
    check("lu_reload_rdata1", ex_rdata1, 32'hA5);
    check_count("lu_reload");

    // $0 load destination and an unused rt match never stall
    set_id(1'b1, 5'd2, 5'd0, 5'd0, 1'b1, 1'b0, 32'h0, 32'h0, 16'h0, 1'b0, 32'h300, C_LW);
    tick();
    set_id(1'b1, 5'd0, 5'd0, 5'd9, 1'b1, 1'b1, 32'h0, 32'h0, 16'h0, 1'b0, 32'h304, C_ADD);
    #1;
    check("zero_reg_no_hazard", {31'b0, hazard_stall}, 32'd0);
    set_id(1'b1, 5'd0, 5'd5, 5'd0, 1'b1, 1'b0, 32'h0, 32'h0, 16'h0, 1'b0, 32'h308, C_LW);
    tick();
    set_id(1'b1, 5'd2, 5'd5, 5'd10, 1'b1, 1'b0, 32'h77, 32'h0, 16'h0, 1'b0, 32'h30C, C_ADD);
    #1;
    check("unused_rt_no_hazard", {31'b0, hazard_stall}, 32'd0);
    tick();
    check("unused_rt_loaded", {31'b0, ex_valid}, 32'd1);
    check("unused_rt_rd", {27'b0, ex_rd}, 32'd10);
    check_count("nonuse");

    // Flush with ext_stall and load_use all asserted
    set_id(1'b1, 5'd1, 5'd5, 5'd0, 1'b1, 1'b0, 32'h0, 32'h0, 16'h0, 1'b0, 32'h400, C_LW);
    tick();
    set_id(1'b1, 5'd5, 5'd5, 5'd11, 1'b1, 1'b1, 32'h1, 32'h2, 16'h3, 1'b0, 32'h404, C_ADD);
    flush = 1'b1;
    ext_stall = 1'b1;
    #1;
    check("simul_hazard", {31'b0, hazard_stall}, 32'd1);
    tick();
    exp_cnt++;
    flush = 1'b0;
    ext_stall = 1'b0;
    check_zero("simul_bubble");
    check_count("simul_bubble");

    // ext_stall freezes the register for three cycles
    set_id(1'b1, 5'd12, 5'd13, 5'd14, 1'b1, 1'b1, 32'hDEAD0001, 32'hBEEF0002, 16'h1234,
           1'b0, 32'h500, C_MIX);
    tick();
    ext_stall = 1'b1;
    set_id(1'b1, 5'd20, 5'd21, 5'd22, 1'b1, 1'b1, 32'h0, 32'h0, 16'hFFFF, 1'b1,
           32'h504, C_ADD);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("stall_hazard", {31'b0, hazard_stall}, 32'd1);
      tick();
      check("stall_rdata1", ex_rdata1, 32'hDEAD0001);
      check("stall_rs", {27'b0, ex_rs}, 32'd12);
      check("stall_imm32", ex_imm32, 32'h00001234);
      check("stall_ctrl", {20'b0, ex_ctrl}, {20'b0, C_MIX});
      check_count("stall");
    end
    ext_stall = 1'b0;

    // Repeated flushes: wide counter keeps counting, 2-bit counter saturates
    flush = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      exp_cnt++;
      check_count("flush_sat");
    end
    flush = 1'b0;
    check("sat_value", {30'b0, s_count}, 32'd3);

    // Reset asserted mid-stall clears without a clock edge
    set_id(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 32'h99, 32'h88, 16'h7FFF, 1'b0,
           32'h600, C_MIX);
    tick();
    ext_stall = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    exp_cnt = 0;
    check_zero("midrst");
    check_count("midrst");
    tick();
    ext_stall = 1'b0;
    rst = 1'b1;
    tick();
    check("postrst_valid", {31'b0, ex_valid}, 32'd1);
    check("postrst_rdata2", ex_rdata2, 32'h88);
    check("postrst_imm32", ex_imm32, 32'h00007FFF);
    check_count("postrst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
